// File: rtl/bb_pwm_decode.sv
// bb_pwm_decode -- recovers the 16-bit speed word from a motor-style PWM
// waveform. A period runs fall-to-fall; the low-phase length (in clk cycles)
// is scaled by CNT_STEP and saturated to 16 bits.
//
// Optional feature macro: BB_PWM_DECODE_GLITCH_FILTER_EN
//   defined   -> a GLITCH_CLKS-cycle stability filter follows the synchronizer
//   undefined -> synchronized input drives the edge detector directly
//
// Ports:
//   clk          single clock domain
//   rst_n        asynchronous active-low reset
//   pwm_in       asynchronous PWM input
//   speed_out    last valid decoded speed (reset 0)
//   speed_oe     one-cycle strobe: speed_out updated (reset 0)
//   period_err   one-cycle strobe: period outside tolerance (reset 0)
//   signal_lost  level: no edge for TIMEOUT_CLKS cycles (reset 1)
//   busy         FSM in LOW or HIGH (reset 0)
module bb_pwm_decode #(
    parameter int unsigned PERIOD_CLKS  = 256,
    parameter int unsigned PERIOD_TOL   = 2,
    parameter int unsigned CNT_STEP     = 256,
    parameter int unsigned TIMEOUT_CLKS = 1024,
    parameter int unsigned GLITCH_CLKS  = 3,
    parameter int unsigned STATE_WIDTH  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [15:0] speed_out,
    output logic        speed_oe,
    output logic        period_err,
    output logic        signal_lost,
    output logic        busy
);

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CLKS);
    localparam logic [15:0] PER_MIN     = 16'(PERIOD_CLKS - PERIOD_TOL);
    localparam logic [15:0] PER_MAX     = 16'(PERIOD_CLKS + PERIOD_TOL);

    if (STATE_WIDTH < 2 || GLITCH_CLKS == 0) begin : g_param_check
        $error("bb_pwm_decode: STATE_WIDTH must be >= 2 and GLITCH_CLKS >= 1");
    end

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronizer, optional filter, edge register
    // ------------------------------------------------------------------
    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_prev;
    logic fall;
    logic rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef BB_PWM_DECODE_GLITCH_FILTER_EN
    localparam int unsigned GW = $clog2(GLITCH_CLKS + 1);

    logic          filt_q;
    logic [GW-1:0] glitch_cnt;

    // The filtered level follows only after GLITCH_CLKS consecutive
    // disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b0;
            glitch_cnt <= '0;
        end else if (sync_q2 == filt_q) begin
            glitch_cnt <= '0;
        end else if (glitch_cnt == GW'(GLITCH_CLKS - 1)) begin
            filt_q     <= sync_q2;
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign fall = level_prev & ~level;
    assign rise = ~level_prev & level;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        latch_low;
    logic        eval_start;
    logic        timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_nxt = ST_LOW;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Edges take priority over a coincident timeout.
    always_comb begin
        latch_low   = 1'b0;
        eval_start  = 1'b0;
        timeout_hit = 1'b0;
        busy        = 1'b0;
        unique case (state)
            ST_LOW: begin
                busy        = 1'b1;
                latch_low   = rise;
                timeout_hit = ~rise & (cnt == TIMEOUT_CNT);
            end
            ST_HIGH: begin
                busy        = 1'b1;
                eval_start  = fall;
                timeout_hit = ~fall & (cnt == TIMEOUT_CNT);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counter, low-phase latch, registered evaluation
    // ------------------------------------------------------------------
    logic [15:0] low_len;
    logic [15:0] period_q;
    logic        eval_q;
    logic [31:0] product;
    logic [15:0] speed_sat;
    logic        period_ok;

    assign product   = 32'(low_len) * 32'(CNT_STEP);
    assign speed_sat = (product > 32'h0000_FFFF) ? 16'hFFFF : product[15:0];
    assign period_ok = (period_q >= PER_MIN) && (period_q <= PER_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (fall) begin
            cnt <= 16'd1;
        end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    // The period is captured on the closing fall and judged one cycle later,
    // so the strobes appear after the edge following the FSM's fall edge.
    // A rise latched in that same cycle cannot disturb the product because
    // low_len updates non-blocking alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_len     <= '0;
            period_q    <= '0;
            eval_q      <= 1'b0;
            speed_out   <= '0;
            speed_oe    <= 1'b0;
            period_err  <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            speed_oe   <= 1'b0;
            period_err <= 1'b0;
            eval_q     <= eval_start;
            if (latch_low) begin
                low_len <= cnt;
            end
            if (eval_start) begin
                period_q <= cnt;
            end
            if (eval_q) begin
                if (period_ok) begin
                    speed_out   <= speed_sat;
                    speed_oe    <= 1'b1;
                    signal_lost <= 1'b0;
                end else begin
                    period_err <= 1'b1;
                end
            end
            if (timeout_hit) begin
                signal_lost <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bb_pwm_decode.md
# bb_pwm_decode

Measures an incoming motor-style PWM waveform and recovers the 16-bit speed word that produced it, the receive-side inverse of the ramped PWM generator. Each period runs from one falling edge of `pwm_in` to the next. The low-phase length is scaled to speed units and emitted with a one-cycle strobe that drops straight into any `speed_in`/`speed_oe` consumer. Used for ESC loopback checking and for capturing external PWM commands.

## Interface
- `PERIOD_CLKS`, 256: nominal PWM period in clk cycles.
- `PERIOD_TOL`, 2: allowed ±deviation of the measured period, in clk cycles.
- `CNT_STEP`, 256: speed LSBs per clk cycle of low time.
- `TIMEOUT_CLKS`, 1024: clk cycles without an edge before the signal is declared lost.
- `GLITCH_CLKS`, 3: stable cycles the filter requires; used only with the filter macro.
- `STATE_WIDTH`, 3: FSM state register width.

- `clk` input 1: single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `pwm_in` input 1: asynchronous PWM input.
- `speed_out` output 16: last valid decoded speed. Reset value 0.
- `speed_oe` output 1: one-cycle strobe, high when `speed_out` has been updated. Reset value 0.
- `period_err` output 1: one-cycle strobe, high when a period fell outside tolerance. Reset value 0.
- `signal_lost` output 1: level output, set on timeout. Reset value 1.
- `busy` output 1: high while the FSM is in LOW or HIGH. Reset value 0.

## Operation
- **Input path:** `pwm_in` → 2-FF synchronizer → edge register. fall = prev & ~cur; rise = ~prev & cur.
- **Counter `cnt`:** 16-bit, increments every cycle and saturates at 0xFFFF. A fall sets it to 1.
- **FSM states:** IDLE, LOW, HIGH. Reset state is IDLE.
  - IDLE: on fall → LOW. Ignore rise.
  - LOW: on rise → latch `low_len <= cnt` and go to HIGH. If `cnt == TIMEOUT_CLKS` → IDLE and set `signal_lost`.
  - HIGH: on fall → evaluate the period (`period = cnt`), then go to LOW (the new period starts). If `cnt == TIMEOUT_CLKS` → IDLE and set `signal_lost`.
- **Evaluation:**
  - Valid when `PERIOD_CLKS-PERIOD_TOL <= period <= PERIOD_CLKS+PERIOD_TOL`.
  - Valid: `speed_out <= min(low_len*CNT_STEP, 0xFFFF)` using a 32-bit product; pulse `speed_oe`; clear `signal_lost`.
  - Invalid: pulse `period_err`; `speed_out` holds; `signal_lost` is unchanged.
- **Rise and fall in the same cycle:** cannot occur after the edge register. The FSM sees at most one edge per cycle.
- **Timeout:** `speed_out` holds its last value and no strobe is issued. A constant-level input never produces `speed_oe`.
- **First period after reset or loss:** IDLE only arms the counter. At least one full period (fall-to-fall) must be seen before the first `speed_oe`.
- **Reset mid-period:** all state clears immediately. The partial period is discarded.

## Timing
- Synchronizer plus edge detect: the first clk edge sampling the new `pwm_in` level is edge 1, and the FSM acts on edge 3.
- `speed_oe` and `period_err` are registered. Each is high for exactly one cycle beginning after clk edge 4 of a closing fall.
- `low_len` in cycles equals the number of clk edges `pwm_in` was sampled low. Equal synchronizer delay on both edges cancels.
- Strobe rate is at most one per period. No backpressure: the consumer must accept `speed_oe` whenever it is asserted.
- `signal_lost` asserts on the cycle after `cnt` reaches `TIMEOUT_CLKS`.

## Configuration
- `BB_PWM_DECODE_GLITCH_FILTER_EN` defined:
  - A digital filter sits after the synchronizer.
  - The filtered level changes only after the synchronized input has held the new level for `GLITCH_CLKS` consecutive cycles. Shorter pulses are dropped.
  - Edge latency grows by `GLITCH_CLKS` cycles. Both edges are delayed equally, so `low_len` is unaffected.
- Undefined: the synchronized input feeds the edge detector directly with no filtering.

## Test plan
- Generator loopback with `pwm_reg` = 32768, period 256 clocks (low 128) → after the second fall, `speed_oe` pulses with `speed_out` = 0x8000. Repeats every 256 cycles; `signal_lost` = 0.
- Low phase of 1 clock, then low phase of 255 clocks → `speed_out` = 0x0100, then 0xFF00.
- Period of 259 clocks (exceeds tolerance 2) → `period_err` pulses, no `speed_oe`, `speed_out` keeps its prior value. A period of 258 → accepted.
- `pwm_in` held high for 2000 cycles → `signal_lost` = 1 after `TIMEOUT_CLKS`, `busy` = 0. Restart with a 64-clock low in a 256 period → `speed_out` = 0x4000 on the second fall, and `signal_lost` clears.
- `rst_n` pulsed low mid-LOW → all outputs return to reset values and FSM = IDLE. The next strobe comes only after a full fresh period.
- With the filter macro, a 2-cycle high glitch inside a 100-clock low → no rise seen, `speed_out` = 100×256 = 0x6400. Without the macro → `period_err` or a short `low_len`.
